rs232_uart: RTL and testbench
=============================

RS232_UART -- requirements
Module: rs232_uart

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, clk_in cycles per bit, even and >= 4.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries, power of 2 and >= 2.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port rxd_in, input, 1 bit: asynchronous serial line in, idle high.
REQ-007 The block SHALL have port txd_out, output, 1 bit: registered serial line out, idle high.
REQ-008 The block SHALL have port rx_data_out, output, DATA_BITS wide: last received word.
REQ-009 The block SHALL have port rx_valid_out, output, 1 bit: one-cycle pulse, rx_data_out is new.
REQ-010 The block SHALL have port rx_err_out, output, 1 bit: one-cycle pulse, framing or parity error.
REQ-011 The block SHALL have port tx_data_in, input, DATA_BITS wide: word to transmit.
REQ-012 The block SHALL have port tx_valid_in, input, 1 bit: tx_data_in is valid.
REQ-013 The block SHALL have port tx_ready_out, output, 1 bit: TX FIFO accepts a write.
REQ-014 The block SHALL have port echo_in, input, 1 bit: loopback mode, received words are queued for TX.
REQ-015 The block SHALL have port ovf_out, output, 1 bit: one-cycle pulse, echo word dropped because the FIFO is full.

Function
REQ-016 rxd_in SHALL pass through a 2-flop synchronizer; every RX decision SHALL use the synchronized value.
REQ-017 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; frame is LSB first with 1 stop bit.
REQ-018 IDLE->START SHALL occur on a synchronized 1->0 edge; START SHALL resample at CLKS_PER_BIT/2; high means glitch and a return to IDLE, low means DATA.
REQ-019 In DATA, PARITY and STOP, RX SHALL sample once every CLKS_PER_BIT cycles after the START mid-point.
REQ-020 If the stop sample is 1, rx_valid_out and updated rx_data_out SHALL appear on the cycle after the sample, with rx_err_out=0.
REQ-021 If the stop sample is 0, rx_err_out SHALL pulse with no rx_valid_out; the FSM SHALL go to WAIT_IDLE until the line is high, then go to IDLE.
REQ-022 The TX FIFO write SHALL be tx_valid_in & tx_ready_out; tx_ready_out = FIFO not full & echo_in=0 & not in reset.
REQ-023 With echo_in=1, each rx_valid_out word SHALL be pushed; if the FIFO is full, the word SHALL be dropped and ovf_out SHALL pulse; tx_valid_in SHALL be ignored.
REQ-024 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; it SHALL pop on IDLE->START, and each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-025 txd_out SHALL go low one cycle after a push into an empty FIFO while TX is IDLE.
REQ-026 If the FIFO is non-empty at the end of STOP, the next START SHALL follow with no idle gap; full and empty SHALL be exact at depth FIFO_DEPTH, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A simultaneous push and pop on a full FIFO SHALL be impossible (ready=0); a simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.

Reset
REQ-028 While rst_in=1, the block SHALL drive txd_out=1, rx_data_out=0, rx_valid_out=0, rx_err_out=0, ovf_out=0, tx_ready_out=0, with both FSMs in IDLE, the FIFO empty and counters at 0.
REQ-029 Reset mid-frame SHALL abort both directions at the next edge; a partial RX word SHALL NOT be reported.

Configuration
REQ-030 With RS232_PARITY_EN defined, a parity bit SHALL follow the data, even parity over the data bits; a mismatch at the RX parity sample SHALL pulse rx_err_out with no rx_valid_out after the stop bit.
REQ-031 Without RS232_PARITY_EN, the PARITY states SHALL be skipped, the frame SHALL be 1+DATA_BITS+1 bits, and parity logic SHALL be absent.

Verification (DATA_BITS=8, CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Drive RX frame 0xA5 -> exactly one rx_valid_out, rx_data_out=0xA5, rx_err_out=0.
REQ-033 Drive a 4-cycle low glitch on rxd_in -> no rx_valid_out, no rx_err_out, RX back in IDLE.
REQ-034 Drive 0x3C with stop bit 0 -> one rx_err_out pulse, no rx_valid_out; the following valid frame 0x11 is received correctly.
REQ-035 Set echo_in=1 and drive 0x3C -> txd_out emits 0,0,0,1,1,1,1,0,0,1, 16 cycles per bit; tx_ready_out stays 0.
REQ-036 Hold tx_valid_in with 0x01..0x06 from idle -> tx_ready_out drops when the FIFO is full; frames leave in order, back-to-back, 160 cycles each.
REQ-037 Assert rst_in mid-TX -> txd_out=1 next cycle; after release the FIFO is empty, tx_ready_out=1, and with RS232_PARITY_EN a corrupted parity on 0xA5 gives rx_err_out.

Source files
------------

// File: rtl/rs232_uart.sv
// RS232 UART: 2-flop synchronised receiver and FIFO-buffered transmitter with echo loopback.
// Define RS232_PARITY_EN to append an even-parity bit after the data bits in both directions.
module rs232_uart #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rxd_in,
    output logic                 txd_out,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    output logic                 rx_err_out,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid_in,
    output logic                 tx_ready_out,
    input  logic                 echo_in,
    output logic                 ovf_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t            r_rx_state, w_rx_next;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
    logic                 r_rx_valid, r_rx_err;
    logic                 w_rx_tick, w_rx_done, w_rx_fail, w_rx_par_bad;

    tx_state_t            r_tx_state, w_tx_next;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [IDX_W-1:0]     r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift, w_push_data, w_head;
    logic                 r_txd, w_txd_next, w_tx_tick, w_tx_pop;
    logic [DATA_BITS-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;
    logic                 w_full, w_empty, w_push, w_tx_ready, w_avail, r_ovf;

`ifdef RS232_PARITY_EN
    logic r_rx_par_err, r_tx_par;
    assign w_rx_par_bad = r_rx_par_err;
`else
    assign w_rx_par_bad = 1'b0;
`endif

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_tick = 1'b0;
        w_rx_done = 1'b0;
        w_rx_fail = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
            RX_START: if (r_rx_cnt == HALF_LAST) begin
                w_rx_tick = 1'b1;
                w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_rx_cnt == BIT_LAST) begin
                w_rx_tick = 1'b1;
`ifdef RS232_PARITY_EN
                if (r_rx_idx == IDX_LAST) w_rx_next = RX_PARITY;
`else
                if (r_rx_idx == IDX_LAST) w_rx_next = RX_STOP;
`endif
            end
`ifdef RS232_PARITY_EN
            RX_PARITY: if (r_rx_cnt == BIT_LAST) begin
                w_rx_tick = 1'b1;
                w_rx_next = RX_STOP;
            end
`endif
            RX_STOP: if (r_rx_cnt == BIT_LAST) begin
                w_rx_tick = 1'b1;
                // A low stop bit may be a break; wait for the line to recover before hunting again.
                if (!r_rx_sync) begin
                    w_rx_fail = 1'b1;
                    w_rx_next = RX_WAIT_IDLE;
                end else begin
                    w_rx_fail = w_rx_par_bad;
                    w_rx_done = !w_rx_par_bad;
                    w_rx_next = RX_IDLE;
                end
            end
            RX_WAIT_IDLE: if (r_rx_sync) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_meta  <= rxd_in;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
            if (r_rx_state == RX_IDLE || r_rx_state == RX_WAIT_IDLE || w_rx_tick) r_rx_cnt <= '0;
            else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            if (r_rx_state == RX_START) r_rx_idx <= '0;
            else if (r_rx_state == RX_DATA && w_rx_tick) r_rx_idx <= r_rx_idx + IDX_W'(1);
            r_rx_valid <= w_rx_done;
            r_rx_err   <= w_rx_fail;
            if (w_rx_done) r_rx_data <= r_rx_shift;
        end
    end

    always_ff @(posedge clk_in) begin
        if (r_rx_state == RX_DATA && w_rx_tick) r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
    end

`ifdef RS232_PARITY_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) r_rx_par_err <= 1'b0;
        else if (r_rx_state == RX_PARITY && w_rx_tick) r_rx_par_err <= r_rx_sync ^ (^r_rx_shift);
    end
`endif

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_tx_ready  = !w_full && !echo_in && !rst_in;
    assign w_push      = echo_in ? (r_rx_valid && !w_full) : (tx_valid_in && w_tx_ready);
    assign w_push_data = echo_in ? r_rx_data : tx_data_in;
    // An idle transmitter takes a word being pushed into an empty FIFO straight through.
    assign w_avail     = !w_empty || w_push;
    assign w_head      = w_empty ? w_push_data : r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_tx_tick   = (r_tx_cnt == BIT_LAST);

    always_comb begin
        w_tx_next  = r_tx_state;
        w_tx_pop   = 1'b0;
        w_txd_next = r_txd;
        case (r_tx_state)
            TX_IDLE: if (w_avail) begin
                w_tx_next  = TX_START;
                w_tx_pop   = 1'b1;
                w_txd_next = 1'b0;
            end
            TX_START: if (w_tx_tick) begin
                w_tx_next  = TX_DATA;
                w_txd_next = r_tx_shift[0];
            end
            TX_DATA: if (w_tx_tick) begin
                if (r_tx_idx == IDX_LAST) begin
`ifdef RS232_PARITY_EN
                    w_tx_next  = TX_PARITY;
                    w_txd_next = r_tx_par;
`else
                    w_tx_next  = TX_STOP;
                    w_txd_next = 1'b1;
`endif
                end else begin
                    w_txd_next = r_tx_shift[1];
                end
            end
`ifdef RS232_PARITY_EN
            TX_PARITY: if (w_tx_tick) begin
                w_tx_next  = TX_STOP;
                w_txd_next = 1'b1;
            end
`endif
            TX_STOP: if (w_tx_tick) begin
                w_tx_next  = w_avail ? TX_START : TX_IDLE;
                w_tx_pop   = w_avail;
                w_txd_next = !w_avail;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_txd      <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_txd      <= w_txd_next;
            if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            if (w_tx_pop) r_tx_idx <= '0;
            else if (r_tx_state == TX_DATA && w_tx_tick) r_tx_idx <= r_tx_idx + IDX_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_tx_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            r_ovf <= echo_in && r_rx_valid && w_full;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_data;
        if (w_tx_pop) begin
            r_tx_shift <= w_head;
`ifdef RS232_PARITY_EN
            r_tx_par   <= ^w_head;
`endif
        end else if (r_tx_state == TX_DATA && w_tx_tick) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    assign txd_out      = r_txd;
    assign rx_data_out  = r_rx_data;
    assign rx_valid_out = r_rx_valid;
    assign rx_err_out   = r_rx_err;
    assign tx_ready_out = w_tx_ready;
    assign ovf_out      = r_ovf;
endmodule

// File: tb/tb_rs232_uart.sv
// Self-checking bench for rs232_uart: random RX/TX traffic against a frame-level queue model.
module tb_rs232_uart;
    localparam int C = 16;
`ifdef RS232_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NSLOT = PAR_EN ? 11 : 10;

    logic       clk_in = 1'b0;
    logic       rst_in, rxd_in, tx_valid_in, echo_in;
    logic [7:0] tx_data_in;
    logic       txd_out, rx_valid_out, rx_err_out, tx_ready_out, ovf_out;
    logic [7:0] rx_data_out;

    rs232_uart #(.DATA_BITS(8), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rxd_in(rxd_in), .txd_out(txd_out),
        .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .rx_err_out(rx_err_out),
        .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
        .echo_in(echo_in), .ovf_out(ovf_out));

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_rx_err = 0;
    int n_ovf = 0;
    int n_ready_echo = 0;
    int exp_err = 0;
    logic [7:0]  rx_got[$], rx_exp[$], tx_exp[$];
    logic [10:0] tx_frames[$];
    bit          tx_steady[$];
    int          tx_start[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (PAR_EN) f[9] = ^d;
        return f;
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rx_valid_out === 1'b1) rx_got.push_back(rx_data_out);
        if (rx_err_out === 1'b1) n_rx_err <= n_rx_err + 1;
        if (ovf_out === 1'b1) n_ovf <= n_ovf + 1;
        if (echo_in && tx_ready_out === 1'b1) n_ready_echo <= n_ready_echo + 1;
    end

    logic [10:0] dec_f;
    bit          dec_steady;
    logic        dec_v;
    int          dec_t0;
    initial begin : tx_decoder
        forever begin
            @(negedge clk_in);
            if (txd_out === 1'b0) begin
                dec_f = '1;
                dec_steady = 1'b1;
                dec_t0 = cyc;
                for (int s = 0; s < NSLOT; s++) begin
                    dec_v = txd_out;
                    for (int k = 1; k < C; k++) begin
                        @(negedge clk_in);
                        if (txd_out !== dec_v) dec_steady = 1'b0;
                    end
                    dec_f[s] = dec_v;
                    if (s < NSLOT - 1) @(negedge clk_in);
                end
                tx_frames.push_back(dec_f);
                tx_steady.push_back(dec_steady);
                tx_start.push_back(dec_t0);
            end
        end
    end

    task automatic drive_bit(input logic v);
        rxd_in = v;
        repeat (C) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ par_flip);
        drive_bit(stop_bit);
        rxd_in = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] w, input bit record);
        int n;
        n = 0;
        tx_data_in = w;
        tx_valid_in = 1'b1;
        while (tx_ready_out !== 1'b1 && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 1000) chk("push_timeout", n, 0);
        @(negedge clk_in);
        tx_valid_in = 1'b0;
        if (record) tx_exp.push_back(w);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_nvalid"}, rx_got.size(), rx_exp.size());
        for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++)
            chk({tag, "_data"}, rx_got[i], rx_exp[i]);
        chk({tag, "_nerr"}, n_rx_err, exp_err);
        rx_got.delete();
        rx_exp.delete();
    endtask

    task automatic wait_tx(input int n);
        int b;
        b = 0;
        while (tx_frames.size() < n && b < 3000) begin
            @(negedge clk_in);
            b++;
        end
    endtask

    task automatic check_tx(input string tag, input bit check_gap);
        chk({tag, "_nframes"}, tx_frames.size(), tx_exp.size());
        for (int i = 0; i < tx_frames.size() && i < tx_exp.size(); i++) begin
            chk({tag, "_frame"}, tx_frames[i], make_frame(tx_exp[i]));
            chk({tag, "_bitwidth"}, tx_steady[i], 1);
            if (check_gap && i > 0) chk({tag, "_gap"}, tx_start[i] - tx_start[i-1], NSLOT * C);
        end
        tx_frames.delete();
        tx_steady.delete();
        tx_start.delete();
        tx_exp.delete();
    endtask

    initial begin
        repeat (60000) @(posedge clk_in);
        $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, 60000);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] w;
        rst_in = 1'b1; rxd_in = 1'b1; tx_valid_in = 1'b0; tx_data_in = '0; echo_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_txd", txd_out, 1);
        chk("rst_rx_data", rx_data_out, 0);
        chk("rst_rx_valid", rx_valid_out, 0);
        chk("rst_rx_err", rx_err_out, 0);
        chk("rst_ovf", ovf_out, 0);
        chk("rst_ready", tx_ready_out, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_rst", tx_ready_out, 1);

        send_frame(8'hA5, 1'b1, 1'b0);
        rx_exp.push_back(8'hA5);
        repeat (4) @(negedge clk_in);
        check_rx("rx_a5");

        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 12)) @(negedge clk_in);
            send_frame(w, 1'b1, 1'b0);
            rx_exp.push_back(w);
        end
        repeat (4) @(negedge clk_in);
        check_rx("rx_rand");

        rxd_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rxd_in = 1'b1;
        repeat (40) @(negedge clk_in);
        check_rx("glitch");
        w = 8'($urandom);
        send_frame(w, 1'b1, 1'b0);
        rx_exp.push_back(w);
        repeat (4) @(negedge clk_in);
        check_rx("after_glitch");

        send_frame(8'h3C, 1'b0, 1'b0);
        exp_err++;
        repeat (20) @(negedge clk_in);
        send_frame(8'h11, 1'b1, 1'b0);
        rx_exp.push_back(8'h11);
        repeat (4) @(negedge clk_in);
        check_rx("stop0");

        echo_in = 1'b1;
        @(negedge clk_in);
        n_ready_echo = 0;
        send_frame(8'h3C, 1'b1, 1'b0);
        rx_exp.push_back(8'h3C);
        tx_exp.push_back(8'h3C);
        for (int i = 0; i < 2; i++) begin
            w = 8'($urandom);
            send_frame(w, 1'b1, 1'b0);
            rx_exp.push_back(w);
            tx_exp.push_back(w);
        end
        wait_tx(3);
        repeat (4) @(negedge clk_in);
        chk("echo_ready_low", n_ready_echo, 0);
        check_rx("echo_rx");
        check_tx("echo_tx", 1'b0);
        echo_in = 1'b0;
        @(negedge clk_in);

        for (int i = 1; i <= 5; i++) push_word(8'(i), 1'b1);
        chk("ready_full", tx_ready_out, 0);
        push_word(8'h06, 1'b1);
        wait_tx(6);
        repeat (4) @(negedge clk_in);
        check_tx("burst", 1'b1);

        chk("ovf_before", n_ovf, 0);
        w = 8'($urandom);
        fork
            send_frame(w, 1'b1, 1'b0);
            begin
                repeat (90) @(negedge clk_in);
                for (int i = 0; i < 5; i++) push_word(8'($urandom), 1'b1);
                echo_in = 1'b1;
            end
        join
        rx_exp.push_back(w);
        repeat (4) @(negedge clk_in);
        chk("ovf_pulse", n_ovf, 1);
        check_rx("ovf_rx");
        wait_tx(5);
        repeat (4) @(negedge clk_in);
        check_tx("ovf_tx", 1'b1);
        echo_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 3; i++) push_word(8'($urandom), 1'b0);
        repeat (50) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_mid_txd", txd_out, 1);
        chk("rst_mid_ready", tx_ready_out, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_ready", tx_ready_out, 1);
        repeat (250) @(negedge clk_in);
        tx_frames.delete(); tx_steady.delete(); tx_start.delete(); tx_exp.delete();
        repeat (300) @(negedge clk_in);
        chk("post_rst_fifo_empty", tx_frames.size(), 0);
        chk("post_rst_txd_idle", txd_out, 1);

        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (C * 6 + 2) @(negedge clk_in);
                rst_in = 1'b1;
                repeat (2) @(negedge clk_in);
                rst_in = 1'b0;
            end
        join
        repeat (20) @(negedge clk_in);
        check_rx("rx_abort");
        w = 8'($urandom);
        send_frame(w, 1'b1, 1'b0);
        rx_exp.push_back(w);
        repeat (4) @(negedge clk_in);
        check_rx("after_abort");

`ifdef RS232_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b1);
        exp_err++;
        repeat (4) @(negedge clk_in);
        check_rx("par_bad");
        send_frame(8'hA5, 1'b1, 1'b0);
        rx_exp.push_back(8'hA5);
        repeat (4) @(negedge clk_in);
        check_rx("par_good");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
